// File: rtl/video_pkg.sv
// Shared video types for the quad-view HDMI scheduler: pixel format,
// quadrant indices and scheduler states.
package video_pkg;
  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    Q_TL = 2'd0,
    Q_TR = 2'd1,
    Q_BL = 2'd2,
    Q_BR = 2'd3
  } quad_t;

  typedef enum logic {
    WAIT_VS,
    ACTIVE
  } sched_state_t;

  localparam rgb565_t FILL_COLOR_DEFAULT = 16'h0000;
endpackage

// File: rtl/hdmi_quad_scheduler_if.sv
// Video-driver, camera-FIFO and status signals of the quad scheduler.
interface hdmi_quad_scheduler_if #(
  parameter int CNT_W = 11,
  parameter int UF_W  = 16
);
  logic               video_vs;
  logic               data_req;
  logic [CNT_W-1:0]   h_disp;
  logic [CNT_W-1:0]   v_disp;
  logic [3:0]         cam_en;
  logic [63:0]        fifo_dout;
  logic [3:0]         fifo_empty;
  logic [3:0]         fifo_rd_en;
  logic               frame_start;
  logic [15:0]        data_out;
  logic               uf_clr;
  logic [4*UF_W-1:0]  uf_cnt;

  modport master (
    output video_vs, data_req, h_disp, v_disp, cam_en, fifo_dout, fifo_empty, uf_clr,
    input  fifo_rd_en, frame_start, data_out, uf_cnt
  );

  modport slave (
    input  video_vs, data_req, h_disp, v_disp, cam_en, fifo_dout, fifo_empty, uf_clr,
    output fifo_rd_en, frame_start, data_out, uf_cnt
  );
endinterface

// File: rtl/hdmi_pos_tracker.sv
// Screen-position tracker: frame/line edge detection, x/y counters,
// latched half sizes and the WAIT_VS/ACTIVE state machine.
module hdmi_pos_tracker
  import video_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vs_i,
  input  logic             req_i,
  input  logic [CNT_W-1:0] h_disp_i,
  input  logic [CNT_W-1:0] v_disp_i,
  output logic             serve_o,
  output quad_t            quad_o,
  output logic             frame_start_o
);
  sched_state_t     state_q, state_d;
  logic             vs_d_q, req_d_q, frame_start_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] half_w_q, half_w_d, half_h_q, half_h_d, x_max_q, x_max_d;
  logic [CNT_W-1:0] x_eff, y_eff;
  logic             vs_rise, req_fall, active;

  assign vs_rise       = vs_i & ~vs_d_q;
  assign req_fall      = req_d_q & ~req_i;
  assign frame_start_o = frame_start_q;

  // A vs edge takes effect in its own cycle, so a coincident request is
  // served as pixel (0,0) using the freshly latched sizes.
  always_comb begin
    state_d  = state_q;
    half_w_d = half_w_q;
    half_h_d = half_h_q;
    x_max_d  = x_max_q;
    x_eff    = x_q;
    y_eff    = y_q;
    if (vs_rise) begin
      state_d  = ACTIVE;
      half_w_d = h_disp_i >> 1;
      half_h_d = v_disp_i >> 1;
      x_max_d  = h_disp_i - CNT_W'(1);
      x_eff    = '0;
      y_eff    = '0;
    end
    active  = (state_d == ACTIVE);
    serve_o = active & req_i;
    quad_o  = quad_t'({y_eff >= half_h_d, x_eff >= half_w_d});
    x_d     = x_eff;
    y_d     = y_eff;
    if (active) begin
      if (req_i) begin
        if (x_eff != x_max_d) x_d = x_eff + CNT_W'(1);
      end else if (req_fall && !vs_rise) begin
        x_d = '0;
        if (y_eff != '1) y_d = y_eff + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= WAIT_VS;
      vs_d_q        <= 1'b0;
      req_d_q       <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      half_w_q      <= '0;
      half_h_q      <= '0;
      x_max_q       <= '0;
    end else begin
      state_q       <= state_d;
      vs_d_q        <= vs_i;
      req_d_q       <= req_i;
      frame_start_q <= vs_rise;
      x_q           <= x_d;
      y_q           <= y_d;
      half_w_q      <= half_w_d;
      half_h_q      <= half_h_d;
      x_max_q       <= x_max_d;
    end
  end
endmodule

// File: rtl/hdmi_quad_scheduler.sv
// 2x2 quad-view scheduler: muxes four camera FIFOs onto the HDMI pixel
// stream by screen position, substituting fill colour and counting underflows.
module hdmi_quad_scheduler
  import video_pkg::*;
#(
  parameter int      CNT_W      = 11,
  parameter int      UF_W       = 16,
  parameter rgb565_t FILL_COLOR = FILL_COLOR_DEFAULT
) (
  input logic                  pixel_clk,
  input logic                  sys_rst,
  hdmi_quad_scheduler_if.slave bus
);
  logic        serve, frame_start;
  quad_t       quad;
  logic [1:0]  qi;
  logic        cam_ok, cam_empty;
  logic [3:0]  rd_en;
  rgb565_t     pix, data_q, data_d;
  logic [UF_W-1:0] uf_q [4];
  logic [UF_W-1:0] uf_d [4];

  hdmi_pos_tracker #(.CNT_W(CNT_W)) u_pos (
    .clk_i         (pixel_clk),
    .rst_i         (sys_rst),
    .vs_i          (bus.video_vs),
    .req_i         (bus.data_req),
    .h_disp_i      (bus.h_disp),
    .v_disp_i      (bus.v_disp),
    .serve_o       (serve),
    .quad_o        (quad),
    .frame_start_o (frame_start)
  );

  assign qi = quad;

  always_comb begin
    cam_ok    = bus.cam_en[qi];
    cam_empty = bus.fifo_empty[qi];
    pix       = bus.fifo_dout[{qi, 4'b0000} +: 16];
    rd_en     = '0;
    data_d    = data_q;
    uf_d      = uf_q;
    if (serve) begin
      if (cam_ok && !cam_empty) begin
        rd_en[qi] = 1'b1;
        data_d    = pix;
      end else begin
        data_d = FILL_COLOR;
      end
      if (cam_ok && cam_empty && uf_q[qi] != '1) uf_d[qi] = uf_q[qi] + UF_W'(1);
    end
    // Clear wins over a same-cycle increment.
    if (bus.uf_clr) begin
      for (int unsigned i = 0; i < 4; i++) uf_d[i] = '0;
    end
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      data_q <= FILL_COLOR;
      for (int unsigned i = 0; i < 4; i++) uf_q[i] <= '0;
    end else begin
      data_q <= data_d;
      uf_q   <= uf_d;
    end
  end

  always_comb begin
    bus.uf_cnt = '0;
    for (int unsigned i = 0; i < 4; i++) bus.uf_cnt[UF_W*i +: UF_W] = uf_q[i];
  end

  assign bus.fifo_rd_en  = rd_en;
  assign bus.data_out    = data_q;
  assign bus.frame_start = frame_start;
endmodule
